// File: rtl/uart_echo_responder.sv
// Echoes frames from uart_rx back to uart_tx through a FIFO, dropping parity failures
// and counting drop and overflow events with saturating counters.
module uart_echo_responder #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter string       PARITY_CHECK = "NONE",
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_vld,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  input  logic                          rx_pc_pass,
  output logic                          rx_rdy,
  input  logic                          tx_rdy,
  output logic                          tx_vld,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          drop_cnt,
  output logic [CNT_WIDTH-1:0]          ovf_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam bit ChkEn = (PARITY_CHECK != "NONE");
  localparam logic [PW-1:0] PtrOne = PW'(1);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic                  full, empty;
  logic                  push, pop, drop, ovf;
  state_e                state_q, state_d;
  logic                  tx_vld_q, tx_vld_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, ovf_cnt_q;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Ready reflects occupancy only; a same-cycle pop does not free a slot early.
  assign rx_rdy = !full;

  assign push = rx_vld && rx_rdy && (!ChkEn || rx_pc_pass);
  assign drop = rx_vld && rx_rdy && ChkEn && !rx_pc_pass;
  assign ovf  = rx_vld && !rx_rdy;

  always_comb begin
    state_d   = state_q;
    tx_vld_d  = 1'b0;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && tx_rdy) begin
          state_d   = StSend;
          tx_vld_d  = 1'b1;
          tx_data_d = mem[rd_ptr_q[AW-1:0]];
          pop       = 1'b1;
        end
      end
      StSend:  state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= StIdle;
      tx_vld_q   <= 1'b0;
      tx_data_q  <= '0;
      drop_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      tx_vld_q  <= tx_vld_d;
      tx_data_q <= tx_data_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      if (drop && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + CntOne;
      end
      if (ovf && (ovf_cnt_q != '1)) begin
        ovf_cnt_q <= ovf_cnt_q + CntOne;
      end
    end
  end

  assign tx_vld     = tx_vld_q;
  assign tx_data    = tx_data_q;
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign drop_cnt   = drop_cnt_q;
  assign ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Scoreboard bench for uart_echo_responder: stimulus pushes expected echoes, a monitor
// pops and compares on every tx_vld pulse.
module tb_uart_echo_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_vld, rx_pc_pass, rx_rdy;
  logic [7:0]  rx_data;
  logic        tx_rdy, tx_vld;
  logic [7:0]  tx_data;
  logic [4:0]  fifo_level;
  logic [15:0] drop_cnt, ovf_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  exp_q[$];
  logic        prev_vld = 1'b0;

  uart_echo_responder #(
    .DATA_WIDTH  (8),
    .PARITY_CHECK("EVEN"),
    .FIFO_DEPTH  (16),
    .CNT_WIDTH   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_vld    (rx_vld),
    .rx_data   (rx_data),
    .rx_pc_pass(rx_pc_pass),
    .rx_rdy    (rx_rdy),
    .tx_rdy    (tx_rdy),
    .tx_vld    (tx_vld),
    .tx_data   (tx_data),
    .fifo_level(fifo_level),
    .drop_cnt  (drop_cnt),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every tx_vld cycle must be an isolated pulse carrying the next expected frame.
  always @(negedge clk) begin
    if (tx_vld) begin
      check("tx_single_pulse", {31'd0, prev_vld}, 32'd0);
      if (exp_q.size() == 0) begin
        check("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        check("tx_data_order", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_vld <= tx_vld;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic pass);
    rx_vld     = 1'b1;
    rx_data    = d;
    rx_pc_pass = pass;
    if (pass) exp_q.push_back(d);
    tick();
    rx_vld = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    tx_rdy = 1'b1;
    while ((exp_q.size() != 0 || fifo_level != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_time", {31'd0, n < budget}, 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_vld = 1'b0; rx_data = '0; rx_pc_pass = 1'b0; tx_rdy = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_level", {27'd0, fifo_level}, 32'd0);
    check("rst_drop", {16'd0, drop_cnt}, 32'd0);
    check("rst_ovf", {16'd0, ovf_cnt}, 32'd0);
    check("rst_rx_rdy", {31'd0, rx_rdy}, 32'd1);

    // Single frame: tx_vld appears two cycles after the rx_vld cycle.
    tx_rdy = 1'b1;
    send(8'h5A, 1'b1);
    check("lat_c1_vld", {31'd0, tx_vld}, 32'd0);
    check("lat_c1_level", {27'd0, fifo_level}, 32'd1);
    tick();
    check("lat_c2_vld", {31'd0, tx_vld}, 32'd1);
    check("lat_c2_data", {24'd0, tx_data}, 32'h5A);
    check("lat_c2_level", {27'd0, fifo_level}, 32'd0);
    tick();
    check("lat_c3_vld", {31'd0, tx_vld}, 32'd0);
    check("lat_c3_data_hold", {24'd0, tx_data}, 32'h5A);
    check("single_drop", {16'd0, drop_cnt}, 32'd0);
    check("single_ovf", {16'd0, ovf_cnt}, 32'd0);
    repeat (2) tick();

    // Fill to full with tx blocked, then overflow for 3 cycles.
    tx_rdy = 1'b0;
    for (int i = 1; i <= 16; i++) send(8'(i), 1'b1);
    check("full_level", {27'd0, fifo_level}, 32'd16);
    check("full_rx_rdy", {31'd0, rx_rdy}, 32'd0);
    rx_vld = 1'b1; rx_data = 8'hEE; rx_pc_pass = 1'b1;
    repeat (3) tick();
    rx_vld = 1'b0;
    check("ovf_cnt_3", {16'd0, ovf_cnt}, 32'd3);
    check("ovf_level", {27'd0, fifo_level}, 32'd16);
    check("tx_idle_blocked", {31'd0, tx_vld}, 32'd0);
    drain(200);
    check("after_drain_level", {27'd0, fifo_level}, 32'd0);
    check("after_drain_rx_rdy", {31'd0, rx_rdy}, 32'd1);

    // Parity drop.
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    drain(50);
    check("parity_drop_cnt", {16'd0, drop_cnt}, 32'd1);
    check("parity_ovf_unchanged", {16'd0, ovf_cnt}, 32'd3);

    // Reset while level=5 and the FSM is in SEND.
    tx_rdy = 1'b0;
    for (int i = 0; i < 6; i++) send(8'h60 + 8'(i), 1'b1);
    tx_rdy = 1'b1;
    tick();
    check("mid_send_vld", {31'd0, tx_vld}, 32'd1);
    check("mid_send_level", {27'd0, fifo_level}, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_vld", {31'd0, tx_vld}, 32'd0);
    check("mid_rst_level", {27'd0, fifo_level}, 32'd0);
    check("mid_rst_drop", {16'd0, drop_cnt}, 32'd0);
    check("mid_rst_ovf", {16'd0, ovf_cnt}, 32'd0);
    send(8'hA5, 1'b1);
    drain(50);

    // Random mix of rx_vld and tx_rdy, never letting the FIFO fill.
    for (int i = 0; i < 400; i++) begin
      tx_rdy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0 && fifo_level < 14) begin
        rx_vld = 1'b1; rx_data = 8'($urandom); rx_pc_pass = 1'b1;
        exp_q.push_back(rx_data);
      end else begin
        rx_vld = 1'b0;
      end
      tick();
    end
    rx_vld = 1'b0;
    drain(400);
    check("rand_ovf", {16'd0, ovf_cnt}, 32'd0);
    check("rand_drop", {16'd0, drop_cnt}, 32'd0);
    check("rand_sb_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
